// File: rtl/game_seq_ctrl.sv
// game_seq_ctrl -- game sequencing controller for a paddle/brick game.
//
// Synchronises and debounces the three board keys, turns the start key into
// a one-shot event, derives a frame tick from the falling edge of vsync, and
// runs the IDLE/SERVE/PLAY/PAUSE/OVER/WIN state machine that gates the game
// core.
//
// Ports
//   sys_clk       in   single system clock, rising edge
//   sys_rst       in   synchronous reset, active-high
//   btn_left_n    in   raw left key, low when pressed
//   btn_right_n   in   raw right key, low when pressed
//   btn_start_n   in   raw start key, low when pressed
//   vsync         in   VGA field sync, active-low pulse
//   ball_lost     in   one-cycle pulse when the ball passes the paddle
//   bricks_clear  in   level, high when no bricks remain
//   left, right   out  gated paddle controls, active-high, registered
//   game_run      out  core motion enable, registered
//   serve         out  one-cycle pulse: re-centre ball and paddle
//   new_game      out  one-cycle pulse: reload bricks
//   lives         out  remaining lives
//   endGame       out  high in OVER or WIN, registered
//   state         out  FSM encoding for debug/LEDs
module game_seq_ctrl #(
  parameter int DEB_CYCLES   = 500000,
  parameter int SERVE_FRAMES = 60,
  parameter int LIVES        = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       btn_left_n,
  input  logic       btn_right_n,
  input  logic       btn_start_n,
  input  logic       vsync,
  input  logic       ball_lost,
  input  logic       bricks_clear,
  output logic       left,
  output logic       right,
  output logic       game_run,
  output logic       serve,
  output logic       new_game,
  output logic [1:0] lives,
  output logic       endGame,
  output logic [2:0] state
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int FW = $clog2(SERVE_FRAMES + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    OVER  = 3'd4,
    WIN   = 3'd5
  } state_t;

  // Key order: 0 = left, 1 = right, 2 = start. All levels active-low.
  logic [2:0] key_raw_n;
  logic [2:0] key_deb_n;

  assign key_raw_n = {btn_start_n, btn_right_n, btn_left_n};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_key
      logic [1:0]    sync_reg;
      logic [DW-1:0] cnt_reg;
      logic          deb_reg;

      // The debounced level only follows the synchronised key after it has
      // disagreed for DEB_CYCLES cycles in a row; any agreement restarts.
      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          sync_reg <= 2'b11;
          cnt_reg  <= '0;
          deb_reg  <= 1'b1;
        end else begin
          sync_reg <= {sync_reg[0], key_raw_n[gi]};
          if (sync_reg[1] != deb_reg) begin
            if (cnt_reg == DW'(DEB_CYCLES - 1)) begin
              deb_reg <= sync_reg[1];
              cnt_reg <= '0;
            end else begin
              cnt_reg <= cnt_reg + DW'(1);
            end
          end else begin
            cnt_reg <= '0;
          end
        end
      end

      assign key_deb_n[gi] = deb_reg;
    end
  endgenerate

  // Start event and frame tick edge detectors.
  logic       start_prev_reg;
  logic [1:0] vsync_sync_reg;
  logic       vsync_prev_reg;
  logic       start_evt;
  logic       frame_tick;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      start_prev_reg <= 1'b1;
      vsync_sync_reg <= 2'b11;
      vsync_prev_reg <= 1'b1;
    end else begin
      start_prev_reg <= key_deb_n[2];
      vsync_sync_reg <= {vsync_sync_reg[0], vsync};
      vsync_prev_reg <= vsync_sync_reg[1];
    end
  end

  assign start_evt  = start_prev_reg & ~key_deb_n[2];
  assign frame_tick = vsync_prev_reg & ~vsync_sync_reg[1];

  // Main sequencer with registered outputs.
  state_t        state_reg;
  logic [1:0]    lives_reg;
  logic [FW-1:0] frame_cnt_reg;
  logic          serve_reg;
  logic          new_game_reg;
  logic          game_run_reg;
  logic          end_game_reg;
  logic          left_reg;
  logic          right_reg;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg     <= IDLE;
      lives_reg     <= 2'd0;
      frame_cnt_reg <= '0;
      serve_reg     <= 1'b0;
      new_game_reg  <= 1'b0;
      game_run_reg  <= 1'b0;
      end_game_reg  <= 1'b0;
      left_reg      <= 1'b0;
      right_reg     <= 1'b0;
    end else begin
      serve_reg    <= 1'b0;
      new_game_reg <= 1'b0;
      game_run_reg <= (state_reg == PLAY);
      end_game_reg <= (state_reg == OVER) || (state_reg == WIN);
      // Pressing both paddle keys cancels out.
      left_reg     <= ~key_deb_n[0] & key_deb_n[1] & game_run_reg;
      right_reg    <= ~key_deb_n[1] & key_deb_n[0] & game_run_reg;

      case (state_reg)
        IDLE, OVER, WIN: begin
          if (start_evt) begin
            state_reg     <= SERVE;
            lives_reg     <= 2'(LIVES);
            frame_cnt_reg <= '0;
            new_game_reg  <= 1'b1;
            serve_reg     <= 1'b1;
          end
        end
        SERVE: begin
          if (frame_tick) begin
            if (frame_cnt_reg != FW'(SERVE_FRAMES))
              frame_cnt_reg <= frame_cnt_reg + FW'(1);
            if (frame_cnt_reg >= FW'(SERVE_FRAMES - 1))
              state_reg <= PLAY;
          end
        end
        PLAY: begin
          // A cleared board wins even if the last ball is lost in the same cycle.
          if (bricks_clear) begin
            state_reg <= WIN;
          end else if (ball_lost) begin
            if (lives_reg > 2'd1) begin
              lives_reg     <= lives_reg - 2'd1;
              serve_reg     <= 1'b1;
              frame_cnt_reg <= '0;
              state_reg     <= SERVE;
            end else begin
              lives_reg <= 2'd0;
              state_reg <= OVER;
            end
          end else if (start_evt) begin
            state_reg <= PAUSE;
          end
        end
        PAUSE: begin
          if (start_evt)
            state_reg <= PLAY;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign left     = left_reg;
  assign right    = right_reg;
  assign game_run = game_run_reg;
  assign serve    = serve_reg;
  assign new_game = new_game_reg;
  assign lives    = lives_reg;
  assign endGame  = end_game_reg;
  assign state    = state_reg;

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Directed testbench for game_seq_ctrl with DEB_CYCLES=4, SERVE_FRAMES=2,
// LIVES=3. Inputs change 1 time unit after the rising edge; outputs are read
// at the same point, after they have settled.
module tb_game_seq_ctrl;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic       btn_left_n, btn_right_n, btn_start_n;
  logic       vsync, ball_lost, bricks_clear;
  logic       left, right, game_run, serve, new_game, endGame;
  logic [1:0] lives;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  // Pulse monitor, sampled on the falling edge.
  int   serve_cnt = 0;
  int   new_game_cnt = 0;
  logic serve_prev = 1'b0;
  logic new_game_prev = 1'b0;
  logic double_pulse = 1'b0;

  game_seq_ctrl #(
    .DEB_CYCLES  (4),
    .SERVE_FRAMES(2),
    .LIVES       (3)
  ) dut (
    .sys_clk     (clk),
    .sys_rst     (sys_rst),
    .btn_left_n  (btn_left_n),
    .btn_right_n (btn_right_n),
    .btn_start_n (btn_start_n),
    .vsync       (vsync),
    .ball_lost   (ball_lost),
    .bricks_clear(bricks_clear),
    .left        (left),
    .right       (right),
    .game_run    (game_run),
    .serve       (serve),
    .new_game    (new_game),
    .lives       (lives),
    .endGame     (endGame),
    .state       (state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (serve) serve_cnt <= serve_cnt + 1;
    if (new_game) new_game_cnt <= new_game_cnt + 1;
    if ((serve && serve_prev) || (new_game && new_game_prev)) double_pulse <= 1'b1;
    serve_prev    <= serve;
    new_game_prev <= new_game;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full start key press: long enough to debounce, then released and settled.
  task automatic press_start();
    btn_start_n = 1'b0;
    repeat (8) step();
    btn_start_n = 1'b1;
    repeat (10) step();
  endtask

  // One vsync low pulse plus settle time for the synchronised tick.
  task automatic frame();
    vsync = 1'b0;
    repeat (2) step();
    vsync = 1'b1;
    repeat (4) step();
  endtask

  task automatic pulse_ball_lost();
    ball_lost = 1'b1;
    step();
    ball_lost = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({left, right, game_run, serve, new_game, lives, endGame, state} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b required 0", {left, right, game_run, serve, new_game, lives, endGame, state});
    end
    sys_rst = 1'b0;
    repeat (2) step();
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL reset_release_state got %0d required 0", state);
    end
    $display("test_reset: state=%0d lives=%0d", state, lives);
  endtask

  task automatic test_short_press();
    int ng0 = new_game_cnt;
    btn_start_n = 1'b0;
    repeat (3) step();
    btn_start_n = 1'b1;
    repeat (10) step();
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL short_press_state got %0d required 0", state);
    end
    checks++;
    if (new_game_cnt !== ng0) begin
      errors++;
      $display("FAIL short_press_new_game got %0d pulses required 0", new_game_cnt - ng0);
    end
    $display("test_short_press: state=%0d", state);
  endtask

  task automatic test_new_game();
    int ng0 = new_game_cnt;
    int sv0 = serve_cnt;
    press_start();
    checks++;
    if (new_game_cnt - ng0 !== 1) begin
      errors++;
      $display("FAIL new_game_pulses got %0d required 1", new_game_cnt - ng0);
    end
    checks++;
    if (serve_cnt - sv0 !== 1) begin
      errors++;
      $display("FAIL new_game_serve_pulses got %0d required 1", serve_cnt - sv0);
    end
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL new_game_state got %0d required 1", state);
    end
    checks++;
    if (lives !== 2'd3) begin
      errors++;
      $display("FAIL new_game_lives got %0d required 3", lives);
    end
    checks++;
    if (game_run !== 1'b0) begin
      errors++;
      $display("FAIL serve_game_run got %0d required 0", game_run);
    end
    $display("test_new_game: state=%0d lives=%0d", state, lives);
  endtask

  task automatic test_serve_to_play();
    frame();
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL serve_one_frame_state got %0d required 1", state);
    end
    frame();
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL serve_two_frames_state got %0d required 2", state);
    end
    checks++;
    if (game_run !== 1'b1) begin
      errors++;
      $display("FAIL play_game_run got %0d required 1", game_run);
    end
    $display("test_serve_to_play: state=%0d game_run=%0d", state, game_run);
  endtask

  task automatic test_paddles();
    btn_left_n = 1'b0;
    repeat (10) step();
    checks++;
    if ({left, right} !== 2'b10) begin
      errors++;
      $display("FAIL paddle_left got %b required 10", {left, right});
    end
    btn_right_n = 1'b0;
    repeat (10) step();
    checks++;
    if ({left, right} !== 2'b00) begin
      errors++;
      $display("FAIL paddle_both got %b required 00", {left, right});
    end
    btn_left_n = 1'b1;
    repeat (10) step();
    checks++;
    if ({left, right} !== 2'b01) begin
      errors++;
      $display("FAIL paddle_right got %b required 01", {left, right});
    end
    btn_right_n = 1'b1;
    repeat (10) step();
    checks++;
    if ({left, right} !== 2'b00) begin
      errors++;
      $display("FAIL paddle_release got %b required 00", {left, right});
    end
    $display("test_paddles: left=%0d right=%0d", left, right);
  endtask

  task automatic test_lives();
    int sv0 = serve_cnt;
    logic [1:0] exp_lives [3];
    exp_lives[0] = 2'd2;
    exp_lives[1] = 2'd1;
    exp_lives[2] = 2'd0;
    for (int i = 0; i < 3; i++) begin
      pulse_ball_lost();
      checks++;
      if (lives !== exp_lives[i]) begin
        errors++;
        $display("FAIL lives_after_loss%0d got %0d required %0d", i, lives, exp_lives[i]);
      end
      checks++;
      if (state !== ((i < 2) ? 3'd1 : 3'd4)) begin
        errors++;
        $display("FAIL state_after_loss%0d got %0d required %0d", i, state, (i < 2) ? 1 : 4);
      end
      frame();
      frame();
      $display("test_lives: loss %0d lives=%0d state=%0d", i, lives, state);
    end
    checks++;
    if (serve_cnt - sv0 !== 2) begin
      errors++;
      $display("FAIL lives_serve_pulses got %0d required 2", serve_cnt - sv0);
    end
    checks++;
    if ({state, endGame, game_run} !== {3'd4, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL game_over got state=%0d endGame=%0d game_run=%0d required 4 1 0", state, endGame, game_run);
    end
  endtask

  task automatic test_win();
    int sv0;
    press_start();
    frame();
    frame();
    checks++;
    if ({state, lives} !== {3'd2, 2'd3}) begin
      errors++;
      $display("FAIL restart_play got state=%0d lives=%0d required 2 3", state, lives);
    end
    sv0 = serve_cnt;
    bricks_clear = 1'b1;
    ball_lost = 1'b1;
    step();
    ball_lost = 1'b0;
    step();
    bricks_clear = 1'b0;
    step();
    checks++;
    if ({state, lives} !== {3'd5, 2'd3}) begin
      errors++;
      $display("FAIL win_priority got state=%0d lives=%0d required 5 3", state, lives);
    end
    checks++;
    if (serve_cnt !== sv0 || endGame !== 1'b1) begin
      errors++;
      $display("FAIL win_outputs got serve_pulses=%0d endGame=%0d required 0 1", serve_cnt - sv0, endGame);
    end
    $display("test_win: state=%0d lives=%0d", state, lives);
  endtask

  task automatic test_pause();
    press_start();
    frame();
    frame();
    press_start();
    checks++;
    if ({state, game_run} !== {3'd3, 1'b0}) begin
      errors++;
      $display("FAIL pause_enter got state=%0d game_run=%0d required 3 0", state, game_run);
    end
    pulse_ball_lost();
    bricks_clear = 1'b1;
    step();
    bricks_clear = 1'b0;
    step();
    checks++;
    if ({state, lives} !== {3'd3, 2'd3}) begin
      errors++;
      $display("FAIL pause_ignore got state=%0d lives=%0d required 3 3", state, lives);
    end
    press_start();
    checks++;
    if ({state, game_run} !== {3'd2, 1'b1}) begin
      errors++;
      $display("FAIL pause_resume got state=%0d game_run=%0d required 2 1", state, game_run);
    end
    $display("test_pause: state=%0d game_run=%0d", state, game_run);
  endtask

  task automatic test_serve_reset();
    int ng0;
    int sv0;
    pulse_ball_lost();
    ng0 = new_game_cnt;
    press_start();
    checks++;
    if ({state, lives} !== {3'd1, 2'd2} || new_game_cnt !== ng0) begin
      errors++;
      $display("FAIL serve_ignore_start got state=%0d lives=%0d new_game_pulses=%0d required 1 2 0", state, lives, new_game_cnt - ng0);
    end
    frame();
    sv0 = serve_cnt;
    ng0 = new_game_cnt;
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    checks++;
    if ({left, right, game_run, serve, new_game, lives, endGame, state} !== 10'd0) begin
      errors++;
      $display("FAIL midserve_reset_outputs got %b required 0", {left, right, game_run, serve, new_game, lives, endGame, state});
    end
    frame();
    frame();
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL post_reset_frame_state got %0d required 0", state);
    end
    checks++;
    if (serve_cnt !== sv0 || new_game_cnt !== ng0) begin
      errors++;
      $display("FAIL post_reset_pulses got serve=%0d new_game=%0d required 0 0", serve_cnt - sv0, new_game_cnt - ng0);
    end
    checks++;
    if (double_pulse !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width got double=%0d required 0", double_pulse);
    end
    $display("test_serve_reset: state=%0d lives=%0d", state, lives);
  endtask

  initial begin
    sys_rst      = 1'b1;
    btn_left_n   = 1'b1;
    btn_right_n  = 1'b1;
    btn_start_n  = 1'b1;
    vsync        = 1'b1;
    ball_lost    = 1'b0;
    bricks_clear = 1'b0;
    test_reset();
    test_short_press();
    test_new_game();
    test_serve_to_play();
    test_paddles();
    test_lives();
    test_win();
    test_pause();
    test_serve_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_seq_ctrl.md
GAME_SEQ_CTRL -- requirements
Module: game_seq_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 500000, meaning the number of consecutive stable cycles before a debounced button changes (10 ms at 50 MHz).
REQ-002 SHALL have parameter SERVE_FRAMES, default 60, meaning the number of frame ticks held in SERVE before play resumes.
REQ-003 SHALL have parameter LIVES, default 3, meaning the lives loaded at new game (range 1..3).
REQ-004 SHALL have port sys_clk, input, 1 bit: the single 50 MHz clock; all logic is on its rising edge.
REQ-005 SHALL have port sys_rst, input, 1 bit: synchronous reset, active-high.
REQ-006 SHALL have ports btn_left_n, btn_right_n and btn_start_n, each input, 1 bit: raw asynchronous board keys, low when pressed.
REQ-007 SHALL have port vsync, input, 1 bit: VGA field sync from the sync generator, active-low pulse.
REQ-008 SHALL have port ball_lost, input, 1 bit: one-cycle pulse from the game core when the ball passes the paddle.
REQ-009 SHALL have port bricks_clear, input, 1 bit: level from the game core, high when no bricks remain.
REQ-010 SHALL have ports left and right, each output, 1 bit: gated paddle controls to the core, active-high.
REQ-011 SHALL have port game_run, output, 1 bit: core motion enable.
REQ-012 SHALL have ports serve and new_game, each output, 1 bit: one-cycle pulses; serve re-centres ball/paddle, new_game reloads bricks.
REQ-013 SHALL have port lives, output, 2 bits: remaining lives.
REQ-014 SHALL have port endGame, output, 1 bit: high in OVER or WIN.
REQ-015 SHALL have port state, output, 3 bits: FSM encoding, for debug and LEDs.

Function
REQ-016 Each raw key SHALL pass a 2-FF synchroniser, then a debouncer: the debounced level updates only after the synchronised input differs from it for DEB_CYCLES consecutive cycles; any reversion clears the counter.
REQ-017 A start event SHALL be a one-cycle pulse on the debounced not-pressed to pressed transition of btn_start_n; holding the key produces no further events.
REQ-018 vsync SHALL be 2-FF synchronised; a frame tick is a one-cycle pulse on its falling edge.
REQ-019 FSM states and encodings SHALL be: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, OVER=4, WIN=5.
REQ-020 On a start event in IDLE, OVER or WIN, the FSM SHALL enter SERVE, load lives=LIVES, clear the frame counter, and pulse new_game and serve in that same transition cycle.
REQ-021 In SERVE, game_run SHALL be 0 and frame ticks are counted; on the SERVE_FRAMES-th tick the FSM SHALL enter PLAY.
REQ-022 In PLAY, game_run SHALL be 1.
REQ-023 In PLAY, bricks_clear=1 SHALL enter WIN and has priority over a same-cycle ball_lost, which is ignored.
REQ-024 In PLAY, ball_lost with lives>1 SHALL decrement lives, pulse serve, clear the frame counter and enter SERVE.
REQ-025 In PLAY, ball_lost with lives=1 SHALL set lives=0 and enter OVER, with no serve pulse.
REQ-026 In PLAY, a start event SHALL enter PAUSE, and a start event in PAUSE SHALL return to PLAY; in PAUSE, game_run=0, and ball_lost and bricks_clear are ignored.
REQ-027 ball_lost and bricks_clear SHALL be ignored outside PLAY.
REQ-028 A start event in SERVE SHALL be ignored.
REQ-029 left SHALL be debounced-left and game_run and not debounced-right; right SHALL be symmetric, so both pressed gives left=right=0.
REQ-030 game_run, endGame, left and right SHALL be registered, changing the cycle after the state change that causes them.
REQ-031 serve and new_game SHALL never be high for more than one consecutive cycle.
REQ-032 The frame counter SHALL saturate at SERVE_FRAMES and never wrap.

Reset
REQ-033 While sys_rst=1 at a clock edge, the FSM SHALL go to IDLE, lives=0, frame counter=0, debounced levels=not pressed, debounce counters=0 and synchronisers=1.
REQ-034 All outputs SHALL be 0 in the cycle after reset.
REQ-035 Reset SHALL take effect in any state, including mid-debounce and mid-SERVE, with no pulse emitted on exit.

Verification (DEB_CYCLES=4, SERVE_FRAMES=2, LIVES=3)
REQ-036 Scenario 1 SHALL hold btn_start_n low for 3 cycles, then high -> no start event and state stays 0; hold it low for 8 cycles -> exactly one new_game and serve pulse, state=1, lives=3.
REQ-037 Scenario 2 SHALL, from SERVE, give 2 vsync falling edges -> state=2 and game_run=1; hold left low -> left=1 after the debounce; then press right as well -> left=right=0.
REQ-038 Scenario 3 SHALL, in PLAY with lives=3, pulse ball_lost three times, each followed by 2 frames -> lives 2, 1, then 0; serve pulses twice; the final state=4 and endGame=1.
REQ-039 Scenario 4 SHALL, in PLAY, raise bricks_clear and ball_lost in the same cycle -> state=5, lives unchanged, no serve pulse.
REQ-040 Scenario 5 SHALL, in PLAY, give a start event -> state=3, game_run=0, and ball_lost is ignored; a second start event -> state=2.
REQ-041 Scenario 6 SHALL assert sys_rst for one cycle in SERVE after 1 frame -> all outputs 0 and state=0, and a subsequent frame tick causes no transition.
